// File: rtl/bitcell_array.sv
// Word-organised single-port register array with registered read, held output
// and a hardware clear sweep that runs after reset and on request.
//
// state | meaning
// IDLE  | accepting reads and writes
// CLEAR | sweeping zeros through every word, one word per cycle
module bitcell_array #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  data,
   input  logic              clr,
   output logic [WIDTH-1:0]  out,
   output logic              out_valid,
   output logic              busy,
   output logic              err
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] ptr, ptr_nx;
   logic              in_range, wr_en, rd_en, err_nx;
   logic [WIDTH-1:0]  mem [DEPTH];

   // Extra top bit keeps the compare honest when DEPTH == 2**ADDR_W.
   assign in_range = ({1'b0, addr} < DEPTH_C);
   assign busy     = (state == CLEAR);

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      err_nx   = 1'b0;
      case (state)
         CLEAR: begin
            err_nx = sel;
            ptr_nx = ptr + 1'b1;
            if (ptr == LAST) begin
               state_nx = IDLE;
               ptr_nx   = '0;
            end
         end
         IDLE: begin
            if (clr) begin
               state_nx = CLEAR;
               ptr_nx   = '0;
               err_nx   = sel;
            end else if (sel) begin
               if (!in_range) err_nx = 1'b1;
               else if (rw)   wr_en  = 1'b1;
               else           rd_en  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= CLEAR;
         ptr       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         out_valid <= rd_en;
         err       <= err_nx;
         if (rd_en) out <= mem[addr];
      end
   end

   // Word 0 is zeroed on every reset edge; the sweep rewrites it right after.
   always_ff @(posedge clk) begin
      if (rst)                 mem[0]    <= '0;
      else if (state == CLEAR) mem[ptr]  <= '0;
      else if (wr_en)          mem[addr] <= data;
   end

endmodule

// File: tb/tb_bitcell_array.sv
// Scoreboard bench for bitcell_array: a word-level model predicts every cycle's
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_bitcell_array;
   localparam int WIDTH  = 8;
   localparam int DEPTH  = 12;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1, sel = 1'b0, rw = 1'b0, clr = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [WIDTH-1:0]  data = '0;
   logic [WIDTH-1:0]  out;
   logic              out_valid, busy, err;

   bitcell_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .sel(sel), .rw(rw), .addr(addr), .data(data),
      .clr(clr), .out(out), .out_valid(out_valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             v;
      logic             e;
      logic             b;
      logic [WIDTH-1:0] o;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   // Reference model: whole-array view, sweep modelled as a busy countdown.
   logic [WIDTH-1:0] m_mem [DEPTH];
   int               m_busy = 0;
   logic [WIDTH-1:0] m_out = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic cyc(input logic r, input logic s, input logic w,
                      input int a, input int d, input logic c);
      exp_t x;
      rst = r; sel = s; rw = w; addr = ADDR_W'(a); data = WIDTH'(d); clr = c;
      x.v = 1'b0;
      x.e = 1'b0;
      if (r) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_busy = DEPTH;
         m_out  = '0;
      end else if (m_busy > 0) begin
         m_busy--;
         x.e = s;
      end else if (c) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_busy = DEPTH;
         x.e = s;
      end else if (s) begin
         if (a >= DEPTH) x.e = 1'b1;
         else if (w) m_mem[a] = WIDTH'(d);
         else begin
            m_out = m_mem[a];
            x.v   = 1'b1;
         end
      end
      x.b = (m_busy > 0);
      x.o = m_out;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask
   task automatic wr(input int a, input int d); cyc(0, 1, 1, a, d, 0); endtask
   task automatic rd(input int a);              cyc(0, 1, 0, a, 0, 0); endtask

   always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("out_valid", 32'(out_valid), 32'(x.v));
         chk("err",       32'(err),       32'(x.e));
         chk("busy",      32'(busy),      32'(x.b));
         chk("out",       32'(out),       32'(x.o));
      end
   end

   initial begin
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      idle(DEPTH);
      for (int i = 0; i < DEPTH; i++) rd(i);
      idle(1);

      wr(3, 8'hA5); wr(12 % DEPTH, 8'h5A);
      rd(3); rd(12 % DEPTH); idle(3);

      wr(7, 8'h3C); rd(7); idle(1);

      for (int i = 0; i < DEPTH; i++) wr(i, i);
      rd(5);
      cyc(0, 1, 0, 4, 0, 1);
      idle(3);
      rd(2);
      cyc(0, 0, 0, 0, 0, 1);
      idle(DEPTH - 5);
      for (int i = 0; i < DEPTH; i++) rd(i);

      wr(13, 8'hEE); wr(4, 8'h44); rd(4);
      rd(13); rd(11); rd(DEPTH - 1); wr(15, 8'h11); idle(1);

      wr(5, 8'h77); rd(5);
      cyc(0, 0, 0, 0, 0, 1);
      idle(4);
      cyc(1, 0, 0, 0, 0, 0);
      idle(DEPTH + 2);
      rd(5);

      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 149) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 15), $urandom_range(0, 255), ($urandom_range(0, 39) == 0));
      end
      idle(2);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
